// File: rtl/datapath_ext_if.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_ext_if
//  Description : Bus bundle between the controller and the datapath.
//                master : controller side (drives instruction word, switches
//                         and all control lines; observes PC, LEDs, flags).
//                slave  : datapath side.
//                Ports carried: MemData, Switches, RegWe, ImmSel, WDataSel,
//                AccWe, Op1Sel, FlagWe, PcWe, AluOp, PcSel (to datapath);
//                Pc, LEDs, Zero, Carry, StackOverflow, StackUnderflow (from).
//  Revision    : 1.0 - initial release
// ============================================================================
interface datapath_ext_if #(
  parameter int N    = 8,
  parameter int PC_N = 5
);
  logic [N-1:0]    MemData;
  logic [N-1:0]    Switches;
  logic            RegWe;
  logic            ImmSel;
  logic            WDataSel;
  logic            AccWe;
  logic            Op1Sel;
  logic            FlagWe;
  logic            PcWe;
  logic [2:0]      AluOp;
  logic [2:0]      PcSel;
  logic [PC_N-1:0] Pc;
  logic [N-1:0]    LEDs;
  logic            Zero;
  logic            Carry;
  logic            StackOverflow;
  logic            StackUnderflow;

  modport master (
    output MemData, Switches, RegWe, ImmSel, WDataSel, AccWe, Op1Sel,
           FlagWe, PcWe, AluOp, PcSel,
    input  Pc, LEDs, Zero, Carry, StackOverflow, StackUnderflow
  );

  modport slave (
    input  MemData, Switches, RegWe, ImmSel, WDataSel, AccWe, Op1Sel,
           FlagWe, PcWe, AluOp, PcSel,
    output Pc, LEDs, Zero, Carry, StackOverflow, StackUnderflow
  );
endinterface
`default_nettype wire

// File: rtl/datapath_ext.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_ext
//  Description : Accumulator datapath with PC, register file, ALU operand
//                muxing, Zero/Carry flags, conditional branches and a
//                hardware call/return stack with sticky error flags.
//                Ports : Clock, Reset (sync, active-high) and the slave side
//                        of datapath_ext_if (all outputs registered).
//  Revision    : 1.0 - initial release
// ============================================================================
module datapath_ext #(
  parameter int N           = 8,
  parameter int PC_N        = 5,
  parameter int NREGS       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  datapath_ext_if.slave        bus
);

  localparam int RA   = $clog2(NREGS);
  localparam int HALF = N / 2;
  localparam int SIW  = $clog2(STACK_DEPTH);
  localparam int SPW  = SIW + 1;   // one extra bit so SP can hold "full"

  localparam logic [2:0] c_alu_a   = 3'b000;
  localparam logic [2:0] c_alu_b   = 3'b001;
  localparam logic [2:0] c_alu_add = 3'b010;
  localparam logic [2:0] c_alu_sub = 3'b011;
  localparam logic [2:0] c_alu_and = 3'b100;
  localparam logic [2:0] c_alu_or  = 3'b101;
  localparam logic [2:0] c_alu_xor = 3'b110;
  localparam logic [2:0] c_alu_not = 3'b111;

  localparam logic [2:0] c_pc_jmp  = 3'b001;
  localparam logic [2:0] c_pc_brz  = 3'b010;
  localparam logic [2:0] c_pc_brc  = 3'b011;
  localparam logic [2:0] c_pc_call = 3'b100;
  localparam logic [2:0] c_pc_ret  = 3'b101;

  localparam logic [PC_N-1:0] c_pc_one = PC_N'(1);
  localparam logic [SPW-1:0]  c_sp_one = SPW'(1);
  localparam logic [SPW-1:0]  c_sp_full = SPW'(STACK_DEPTH);

  // State
  logic [PC_N-1:0] pc_q, pc_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [N-1:0]    regs_q [NREGS];
  logic [N-1:0]    regs_d [NREGS];
  logic            zero_q, zero_d;
  logic            carry_q, carry_d;
  logic [SPW-1:0]  sp_q, sp_d;
  logic [PC_N-1:0] stack_q [STACK_DEPTH];
  logic [PC_N-1:0] stack_d [STACK_DEPTH];
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  // Combinational helpers
  logic [RA-1:0]   w_raddr;
  logic [N-1:0]    w_imm;
  logic [N-1:0]    w_op1;
  logic [N:0]      w_sum;
  logic [N:0]      w_diff;
  logic [N-1:0]    w_result;
  logic            w_carry;
  logic [PC_N-1:0] w_pc_inc;
  logic [PC_N-1:0] w_target;
  logic [SPW-1:0]  w_sp_dec;

  always_comb begin
    w_raddr  = bus.MemData[RA-1:0];
    w_imm    = bus.ImmSel ? {bus.MemData[HALF-1:0], {HALF{1'b0}}}
                          : {{HALF{1'b0}}, bus.MemData[HALF-1:0]};
    w_op1    = bus.Op1Sel ? w_imm : regs_q[w_raddr];

    // One extra bit captures carry-out (ADD) and borrow (SUB)
    w_sum    = {1'b0, acc_q} + {1'b0, w_op1};
    w_diff   = {1'b0, acc_q} - {1'b0, w_op1};

    w_result = w_op1;
    w_carry  = 1'b0;
    case (bus.AluOp)
      c_alu_a:   w_result = w_op1;
      c_alu_b:   w_result = acc_q;
      c_alu_add: begin w_result = w_sum[N-1:0];  w_carry = w_sum[N];  end
      c_alu_sub: begin w_result = w_diff[N-1:0]; w_carry = w_diff[N]; end
      c_alu_and: w_result = acc_q & w_op1;
      c_alu_or:  w_result = acc_q | w_op1;
      c_alu_xor: w_result = acc_q ^ w_op1;
      c_alu_not: w_result = ~w_op1;
      default:   w_result = w_op1;
    endcase

    // Register file: write uses pre-edge Acc, so a same-cycle AccWe cannot
    // leak the new accumulator value into the register.
    regs_d = regs_q;
    if (bus.RegWe)
      regs_d[w_raddr] = bus.WDataSel ? bus.Switches : acc_q;

    acc_d   = acc_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    if (bus.AccWe) begin
      acc_d = w_result;
      if (bus.FlagWe) begin
        zero_d  = (w_result == '0);
        carry_d = w_carry;
      end
    end

    // Program counter and return stack. Branch decisions read the flag
    // flops directly, i.e. the values before this edge.
    w_pc_inc = pc_q + c_pc_one;
    w_target = acc_q[PC_N-1:0];
    w_sp_dec = sp_q - c_sp_one;
    pc_d     = pc_q;
    sp_d     = sp_q;
    stack_d  = stack_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (bus.PcWe) begin
      case (bus.PcSel)
        c_pc_jmp: pc_d = w_target;
        c_pc_brz: pc_d = zero_q  ? w_target : w_pc_inc;
        c_pc_brc: pc_d = carry_q ? w_target : w_pc_inc;
        c_pc_call: begin
          pc_d = w_target;
          if (sp_q == c_sp_full) begin
            ovf_d = 1'b1;
          end else begin
            stack_d[sp_q[SIW-1:0]] = w_pc_inc;
            sp_d = sp_q + c_sp_one;
          end
        end
        c_pc_ret: begin
          if (sp_q == '0) begin
            pc_d  = w_pc_inc;
            unf_d = 1'b1;
          end else begin
            pc_d = stack_q[w_sp_dec[SIW-1:0]];
            sp_d = w_sp_dec;
          end
        end
        default: pc_d = w_pc_inc;   // Inc and the unused 11x codes
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q    <= '0;
      acc_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++)       regs_q[i]  <= '0;
      for (int j = 0; j < STACK_DEPTH; j++) stack_q[j] <= '0;
    end else begin
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      regs_q  <= regs_d;
      stack_q <= stack_d;
    end
  end

  assign bus.Pc             = pc_q;
  assign bus.LEDs           = acc_q;
  assign bus.Zero           = zero_q;
  assign bus.Carry          = carry_q;
  assign bus.StackOverflow  = ovf_q;
  assign bus.StackUnderflow = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_datapath_ext.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datapath_ext
//  Description : Self-checking bench for datapath_ext. A table of one-cycle
//                vectors with hand-computed expected outputs, followed by
//                hand-written call-stack overflow and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_ext;

  // Control-word bits: {RegWe, ImmSel, WDataSel, AccWe, Op1Sel, FlagWe, PcWe}
  localparam logic [6:0] c_pcwe = 7'b0000001;
  localparam logic [6:0] c_fw   = 7'b0000010;
  localparam logic [6:0] c_imm  = 7'b0000100;
  localparam logic [6:0] c_acc  = 7'b0001000;
  localparam logic [6:0] c_wsw  = 7'b0010000;
  localparam logic [6:0] c_hi   = 7'b0100000;
  localparam logic [6:0] c_rw   = 7'b1000000;

  localparam logic [2:0] A = 3'd0, ADD = 3'd2, SUB = 3'd3,
                         AND_ = 3'd4, XOR_ = 3'd6, NOT_ = 3'd7;
  localparam logic [2:0] INC = 3'd0, JMP = 3'd1, BRZ = 3'd2, BRC = 3'd3,
                         CALL = 3'd4, RET = 3'd5;

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] mem;
    logic [7:0] sw;
    logic [6:0] ctrl;
    logic [2:0] alu;
    logic [2:0] pcs;
    logic [4:0] e_pc;
    logic [7:0] e_leds;
    logic [3:0] e_flags;   // {Zero, Carry, StackOverflow, StackUnderflow}
  } vec_t;

  logic Clock;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  datapath_ext_if #(.N(8), .PC_N(5)) bus ();

  datapath_ext #(.N(8), .PC_N(5), .NREGS(8), .STACK_DEPTH(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic vec_t mk(string nm, logic r, logic [7:0] m, logic [7:0] s,
                              logic [6:0] c, logic [2:0] al, logic [2:0] ps,
                              logic [4:0] epc, logic [7:0] el, logic [3:0] ef);
    vec_t v;
    v.name = nm; v.rst = r; v.mem = m; v.sw = s; v.ctrl = c; v.alu = al;
    v.pcs = ps; v.e_pc = epc; v.e_leds = el; v.e_flags = ef;
    return v;
  endfunction

  task automatic step(input vec_t v);
    logic [3:0] got_f;
    @(negedge Clock);
    Reset        = v.rst;
    bus.MemData  = v.mem;
    bus.Switches = v.sw;
    bus.RegWe    = v.ctrl[6];
    bus.ImmSel   = v.ctrl[5];
    bus.WDataSel = v.ctrl[4];
    bus.AccWe    = v.ctrl[3];
    bus.Op1Sel   = v.ctrl[2];
    bus.FlagWe   = v.ctrl[1];
    bus.PcWe     = v.ctrl[0];
    bus.AluOp    = v.alu;
    bus.PcSel    = v.pcs;
    @(posedge Clock);
    #1;
    got_f = {bus.Zero, bus.Carry, bus.StackOverflow, bus.StackUnderflow};
    checks++;
    if (bus.Pc !== v.e_pc || bus.LEDs !== v.e_leds || got_f !== v.e_flags) begin
      errors++;
      $display("FAIL %s: got pc=%0d leds=%h zcou=%b, expected pc=%0d leds=%h zcou=%b",
               v.name, bus.Pc, bus.LEDs, got_f, v.e_pc, v.e_leds, v.e_flags);
    end
  endtask

  initial begin
    Reset = 1'b1;
    bus.MemData = '0; bus.Switches = '0; bus.RegWe = 0; bus.ImmSel = 0;
    bus.WDataSel = 0; bus.AccWe = 0; bus.Op1Sel = 0; bus.FlagWe = 0;
    bus.PcWe = 0; bus.AluOp = '0; bus.PcSel = '0;

    // ---- Table of one-cycle vectors (state carries from row to row) ----
    tbl.push_back(mk("reset",      1, 8'h00, 8'h00, 7'b0, A, INC,  5'd0,  8'h00, 4'b0000));
    tbl.push_back(mk("inc1",       0, 8'h00, 8'h00, c_pcwe, A, INC, 5'd1,  8'h00, 4'b0000));
    tbl.push_back(mk("inc2",       0, 8'h00, 8'h00, c_pcwe, A, INC, 5'd2,  8'h00, 4'b0000));
    tbl.push_back(mk("inc3",       0, 8'h00, 8'h00, c_pcwe, A, INC, 5'd3,  8'h00, 4'b0000));
    tbl.push_back(mk("pc_hold",    0, 8'h00, 8'h00, 7'b0, A, INC,   5'd3,  8'h00, 4'b0000));
    tbl.push_back(mk("imm_lo",     0, 8'h55, 8'h00, c_acc|c_imm, A, INC, 5'd3, 8'h05, 4'b0000));
    tbl.push_back(mk("imm_hi",     0, 8'h55, 8'h00, c_acc|c_imm|c_hi, A, INC, 5'd3, 8'h50, 4'b0000));
    tbl.push_back(mk("add_55",     0, 8'h55, 8'h00, c_acc|c_imm, ADD, INC, 5'd3, 8'h55, 4'b0000));
    tbl.push_back(mk("load_f0",    0, 8'h0F, 8'h00, c_acc|c_imm|c_hi, A, INC, 5'd3, 8'hF0, 4'b0000));
    tbl.push_back(mk("add_wrap",   0, 8'h01, 8'h00, c_acc|c_imm|c_hi|c_fw, ADD, INC, 5'd3, 8'h00, 4'b1100));
    tbl.push_back(mk("sub_borrow", 0, 8'h01, 8'h00, c_acc|c_imm|c_fw, SUB, INC, 5'd3, 8'hFF, 4'b0100));
    tbl.push_back(mk("and_clr_c",  0, 8'h0F, 8'h00, c_acc|c_imm|c_fw, AND_, INC, 5'd3, 8'h0F, 4'b0000));
    tbl.push_back(mk("xor_zero",   0, 8'h0F, 8'h00, c_acc|c_imm|c_fw, XOR_, INC, 5'd3, 8'h00, 4'b1000));
    tbl.push_back(mk("not_nofw",   0, 8'h00, 8'h00, c_acc|c_imm, NOT_, INC, 5'd3, 8'hFF, 4'b1000));
    tbl.push_back(mk("brz_taken",  0, 8'h00, 8'h00, c_pcwe, A, BRZ, 5'd31, 8'hFF, 4'b1000));
    tbl.push_back(mk("inc_wrap",   0, 8'h00, 8'h00, c_pcwe, A, INC, 5'd0,  8'hFF, 4'b1000));
    tbl.push_back(mk("brc_not",    0, 8'h00, 8'h00, c_pcwe, A, BRC, 5'd1,  8'hFF, 4'b1000));
    tbl.push_back(mk("wr_r1_sw",   0, 8'h01, 8'hAA, c_rw|c_wsw, A, INC, 5'd1, 8'hFF, 4'b1000));
    tbl.push_back(mk("rd_r1",      0, 8'h01, 8'h00, c_acc, A, INC, 5'd1, 8'hAA, 4'b1000));
    tbl.push_back(mk("wr_r2_sw",   0, 8'h02, 8'h33, c_rw|c_wsw, A, INC, 5'd1, 8'hAA, 4'b1000));
    tbl.push_back(mk("rw_same",    0, 8'h02, 8'h00, c_rw|c_acc, A, INC, 5'd1, 8'h33, 4'b1000));
    tbl.push_back(mk("rd_r2_old",  0, 8'h02, 8'h00, c_acc, A, INC, 5'd1, 8'hAA, 4'b1000));
    tbl.push_back(mk("sub_equal",  0, 8'h01, 8'h00, c_acc|c_fw, SUB, INC, 5'd1, 8'h00, 4'b1000));
    tbl.push_back(mk("acc10_inc",  0, 8'h01, 8'h00, c_acc|c_imm|c_hi|c_pcwe, A, INC, 5'd2, 8'h10, 4'b1000));
    tbl.push_back(mk("acc14_inc",  0, 8'h04, 8'h00, c_acc|c_imm|c_pcwe, ADD, INC, 5'd3, 8'h14, 4'b1000));
    tbl.push_back(mk("call_20",    0, 8'h00, 8'h00, c_pcwe, A, CALL, 5'd20, 8'h14, 4'b1000));
    tbl.push_back(mk("acc08",      0, 8'h08, 8'h00, c_acc|c_imm, A, INC, 5'd20, 8'h08, 4'b1000));
    tbl.push_back(mk("call_8",     0, 8'h00, 8'h00, c_pcwe, A, CALL, 5'd8,  8'h08, 4'b1000));
    tbl.push_back(mk("ret_21",     0, 8'h00, 8'h00, c_pcwe, A, RET,  5'd21, 8'h08, 4'b1000));
    tbl.push_back(mk("ret_4",      0, 8'h00, 8'h00, c_pcwe, A, RET,  5'd4,  8'h08, 4'b1000));
    tbl.push_back(mk("ret_under",  0, 8'h00, 8'h00, c_pcwe, A, RET,  5'd5,  8'h08, 4'b1001));
    tbl.push_back(mk("under_stky", 0, 8'h00, 8'h00, c_pcwe, A, INC,  5'd6,  8'h08, 4'b1001));
    tbl.push_back(mk("brz_oldflg", 0, 8'h01, 8'h00, c_acc|c_imm|c_fw|c_pcwe, SUB, BRZ, 5'd8, 8'h07, 4'b0001));
    tbl.push_back(mk("brz_not",    0, 8'h00, 8'h00, c_pcwe, A, BRZ,  5'd9,  8'h07, 4'b0001));
    tbl.push_back(mk("jmp_sub",    0, 8'h08, 8'h00, c_acc|c_imm|c_fw|c_pcwe, SUB, JMP, 5'd7, 8'hFF, 4'b0101));
    tbl.push_back(mk("brc_taken",  0, 8'h00, 8'h00, c_pcwe, A, BRC,  5'd31, 8'hFF, 4'b0101));
    tbl.push_back(mk("sel110_inc", 0, 8'h00, 8'h00, c_pcwe, A, 3'd6, 5'd0,  8'hFF, 4'b0101));
    tbl.push_back(mk("sel111_inc", 0, 8'h00, 8'h00, c_pcwe, A, 3'd7, 5'd1,  8'hFF, 4'b0101));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // ---- Stack overflow: five calls into a four-entry stack ----
    step(mk("ov_reset",  1, 8'h00, 8'h00, 7'b0, A, INC, 5'd0, 8'h00, 4'b0000));
    step(mk("ov_acc05",  0, 8'h05, 8'h00, c_acc|c_imm, A, INC, 5'd0, 8'h05, 4'b0000));
    for (int k = 0; k < 4; k++)
      step(mk("ov_call", 0, 8'h00, 8'h00, c_pcwe, A, CALL, 5'd5, 8'h05, 4'b0000));
    step(mk("ov_call5",  0, 8'h00, 8'h00, c_pcwe, A, CALL, 5'd5, 8'h05, 4'b0010));
    step(mk("ov_ret",    0, 8'h00, 8'h00, c_pcwe, A, RET,  5'd6, 8'h05, 4'b0010));

    // ---- Reset with a call pending, then SP must read as empty ----
    step(mk("rst_call",  1, 8'h00, 8'h00, c_pcwe, A, CALL, 5'd0, 8'h00, 4'b0000));
    step(mk("rst_ret",   0, 8'h00, 8'h00, c_pcwe, A, RET,  5'd1, 8'h00, 4'b0001));
    step(mk("rst_inc",   0, 8'h00, 8'h00, c_pcwe, A, INC,  5'd2, 8'h00, 4'b0001));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/datapath_ext.md
Name: datapath_ext

Overview:
Parametrised successor to the 8-bit accumulator datapath. It holds the PC, the accumulator, a register file, ALU operand muxing and the Switches/LEDs I/O, all driven by external control lines from the controller. New in this generation: Zero/Carry status flags, conditional branches, and a hardware call/return stack with sticky overflow/underflow error flags.

Parameters:
n, 8, data/accumulator/register width (even, >=4)
pc_n, 5, PC width (pc_n <= n)
nregs, 8, register file depth (power of 2, 2..2**(n/2)); ra = log2(nregs)
stack_depth, 4, return-stack entries (power of 2, >=2)

Ports:
Clock  in  1  system clock, all state updates on rising edge
Reset  in  1  synchronous reset, active-high
MemData  in  n  instruction word: immediate source and register address
Switches  in  n  external input data
Pc  out  pc_n  current program counter (registered)
LEDs  out  n  accumulator value (registered)
RegWe  in  1  register file write enable
ImmSel  in  1  0: imm = MemData[n/2-1:0] zero-extended; 1: imm = MemData[n/2-1:0] << n/2
WDataSel  in  1  register write data: 0 = Acc, 1 = Switches
AccWe  in  1  accumulator write enable
Op1Sel  in  1  ALU Op1: 0 = Reg[MemData[ra-1:0]], 1 = imm
FlagWe  in  1  flag update enable (effective only with AccWe)
PcWe  in  1  PC/stack update enable
AluOp  in  3  000 A(=Op1), 001 B(=Acc), 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 NOT Op1
PcSel  in  3  000 Inc, 001 Jmp, 010 BrZ, 011 BrC, 100 Call, 101 Ret, 11x = Inc
Zero  out  1  registered zero flag
Carry  out  1  registered carry/borrow flag
StackOverflow  out  1  sticky: Call attempted with stack full
StackUnderflow  out  1  sticky: Ret attempted with stack empty

Behaviour:
- Reset (sampled at the rising edge, dominates all enables): Pc=0, Acc=0 (LEDs=0), all registers=0, Zero=0, Carry=0, SP=0 (empty), both error flags=0. Asserting Reset mid-sequence discards any pending push/pop.
- Register read is combinational from MemData[ra-1:0]. Write address is the same field. Write data per WDataSel. A write takes effect at the edge. A same-cycle read returns the old value.
- ALU: ADD = Acc + Op1; SUB = Acc - Op1; all operations are n-bit with modulo wrap. Acc <= result when AccWe.
- Flags update only when AccWe & FlagWe:
  - Zero <= (result == 0).
  - Carry <= carry-out of ADD; borrow (Acc < Op1, unsigned) for SUB; 0 for all other ops.
- RegWe and AccWe in the same cycle: the register receives the old Acc (or Switches), and Acc receives the ALU result computed from the old register value.
- PC, only when PcWe=1 (otherwise Pc, SP and the stack hold):
  - Inc: Pc+1, wraps 2**pc_n-1 -> 0.
  - Jmp: Acc[pc_n-1:0].
  - BrZ: Acc[pc_n-1:0] if registered Zero=1, else Pc+1.
  - BrC: same as BrZ, using Carry.
  - Branches use the flag value before the edge, even when the flags update in the same cycle.
  - Call: push Pc+1 (wrapped), SP++, Pc <= Acc[pc_n-1:0].
  - Ret: Pc <= top, SP--.
- Stack full (SP == stack_depth) on Call: jump still taken, push discarded, SP unchanged, StackOverflow <= 1.
- Stack empty on Ret: Pc <= Pc+1, SP unchanged, StackUnderflow <= 1.
- Error flags clear only on Reset.
- Latency: every register/flag/PC change is visible 1 cycle after the enabling edge. No combinational path from inputs to any output.

Test Plan:
- Reset, then PcWe=1/Inc for 3 cycles -> Pc=1,2,3. PcWe=0 -> Pc holds at 3. With pc_n=5, start at Pc=31 -> Pc wraps to 0.
- MemData=8'h55, Op1Sel=1, AluOp=A, AccWe=1: ImmSel=0 -> LEDs=8'h05; ImmSel=1 -> LEDs=8'h50. Then ImmSel=0, ADD -> LEDs=8'h55.
- Acc=8'hF0, ADD imm 8'h10 with FlagWe -> LEDs=8'h00, Zero=1, Carry=1. Then SUB imm 8'h01 -> LEDs=8'hFF, Carry=1 (borrow), Zero=0.
- Switches=8'hAA, MemData=8'h01, RegWe=1, WDataSel=1 -> Reg1=8'hAA. Then Op1Sel=0, AluOp=A, AccWe=1 -> LEDs=8'hAA. Same-cycle RegWe+AccWe check returns the old register value.
- Acc=8'h14, Pc=3, Call -> Pc=20. Set Acc=8'h08, Call -> Pc=8. Ret -> Pc=21. Ret -> Pc=4. A further Ret -> Pc=5 and StackUnderflow=1, which persists until Reset.
- With Zero=0, BrZ -> Pc+1; with Zero=1, BrZ -> Acc[4:0]. Five Calls with stack_depth=4 -> 5th still jumps and StackOverflow=1. Reset during this sequence -> Pc=0 and both error flags=0.
